// File: rtl/fpga_ram_tcdm_bridge.sv
// ----------------------------------------------------------------------------
// fpga_ram_tcdm_bridge
//
// Purpose:
//   Bridges a single-master TCDM port onto a private single-port RAM bank.
//   The RAM read data is registered (1-cycle latency). Every granted
//   request, read or write, gets exactly one response on the next cycle.
//   Grants are combinational and have zero wait states once the bridge is
//   ready.
//
//   Optional feature (macro FPGA_RAM_SCRUB_EN): after reset, the bridge
//   first zero-fills the whole bank with one write per cycle, walking
//   addresses 0 .. 2**ADDR_WIDTH-1. TCDM traffic is held off (gnt_o = 0)
//   until the last scrub write has been issued. Without the macro, the
//   bridge is ready from the first cycle after reset release and no scrub
//   logic is built.
//
// Parameters:
//   ADDR_WIDTH  RAM word-address width; must match the attached bank.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       synchronous active-low reset
//   req_i        TCDM request
//   gnt_o        TCDM grant
//   add_i        TCDM byte address; only bits [ADDR_WIDTH+1:2] are used
//   wen_i        0 = write, 1 = read
//   be_i         byte enables
//   wdata_i      write data
//   r_valid_o    response valid, one cycle after each grant
//   r_rdata_o    read data (zero for write responses and when idle)
//   init_done_o  high while the bridge accepts traffic
//   ram_csn_o    RAM chip select, active low
//   ram_wen_o    RAM write enable, active low
//   ram_be_o     RAM byte enables
//   ram_addr_o   RAM word address
//   ram_wdata_o  RAM write data
//   ram_rdata_i  RAM read data, valid the cycle after a read access
// ----------------------------------------------------------------------------
module fpga_ram_tcdm_bridge #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [31:0]           add_i,
    input  logic                  wen_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    output logic                  r_valid_o,
    output logic [31:0]           r_rdata_o,
    output logic                  init_done_o,
    output logic                  ram_csn_o,
    output logic                  ram_wen_o,
    output logic [3:0]            ram_be_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i
);

    logic                  ready;
    logic                  scrub_act;
    logic [ADDR_WIDTH-1:0] scrub_addr;
    logic                  vld_p1;
    logic                  rd_p1;

    // Address bits outside the word index are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{add_i[31:ADDR_WIDTH+2], add_i[1:0]};

`ifdef FPGA_RAM_SCRUB_EN
    typedef enum logic {
        SCRUB = 1'b0,
        READY = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= SCRUB;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter stops on the all-ones address instead of wrapping, so
    // address 0 is never rewritten; READY is terminal until reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == SCRUB) begin
            if (&cnt_q) begin
                state_d = READY;
            end else begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
        end
    end

    assign ready      = (state_q == READY);
    assign scrub_act  = rst_ni && (state_q == SCRUB);
    assign scrub_addr = cnt_q;
`else
    logic init_done_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            init_done_q <= 1'b0;
        end else begin
            init_done_q <= 1'b1;
        end
    end

    assign ready      = init_done_q;
    assign scrub_act  = 1'b0;
    assign scrub_addr = '0;
`endif

    // rst_ni gates the grant so no access leaks out while reset is applied,
    // even before the first reset edge has cleared the state register.
    assign gnt_o       = req_i && ready && rst_ni;
    assign init_done_o = ready;

    always_comb begin
        ram_csn_o   = 1'b1;
        ram_wen_o   = 1'b1;
        ram_be_o    = 4'h0;
        ram_addr_o  = '0;
        ram_wdata_o = 32'h0;
        if (scrub_act) begin
            ram_csn_o   = 1'b0;
            ram_wen_o   = 1'b0;
            ram_be_o    = 4'hF;
            ram_addr_o  = scrub_addr;
            ram_wdata_o = 32'h0;
        end else if (ready) begin
            ram_csn_o   = ~(req_i & gnt_o);
            ram_wen_o   = wen_i;
            ram_be_o    = be_i;
            ram_addr_o  = add_i[ADDR_WIDTH+1:2];
            ram_wdata_o = wdata_i;
        end
    end

    // ---- stage p0 -> p1: grant registered alongside the RAM access ----
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= gnt_o;
        end
    end

    always_ff @(posedge clk_i) begin
        rd_p1 <= wen_i;
    end

    // ---- stage p1: response, RAM read data arrives this cycle ----
    assign r_valid_o = vld_p1;
    assign r_rdata_o = (vld_p1 && rd_p1) ? ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_fpga_ram_tcdm_bridge.sv
module tb_fpga_ram_tcdm_bridge;

    localparam int AW    = 4;
    localparam int WORDS = 1 << AW;
`ifdef FPGA_RAM_SCRUB_EN
    localparam bit SCRUB_M  = 1'b1;
    localparam int READY_AT = WORDS;
`else
    localparam bit SCRUB_M  = 1'b0;
    localparam int READY_AT = 1;
`endif

    logic          clk;
    logic          rst_n;
    logic          req;
    logic          gnt;
    logic [31:0]   add;
    logic          wen;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic          r_valid;
    logic [31:0]   r_rdata;
    logic          init_done;
    logic          ram_csn;
    logic          ram_wen;
    logic [3:0]    ram_be;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_q;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    fpga_ram_tcdm_bridge #(.ADDR_WIDTH(AW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .gnt_o       (gnt),
        .add_i       (add),
        .wen_i       (wen),
        .be_i        (be),
        .wdata_i     (wdata),
        .r_valid_o   (r_valid),
        .r_rdata_o   (r_rdata),
        .init_done_o (init_done),
        .ram_csn_o   (ram_csn),
        .ram_wen_o   (ram_wen),
        .ram_be_o    (ram_be),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] seed(int i);
        return 32'hA5C3_0000 ^ (32'(i) * 32'h0101_0107);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- RAM bank: registered read, byte-enabled write ----
    logic [31:0] ram [WORDS];
    bit          ram_seeded = 1'b0;
    always @(posedge clk) begin
        if (!ram_seeded) begin
            for (int i = 0; i < WORDS; i++) ram[i] <= seed(i);
            ram_seeded <= 1'b1;
        end else if (!ram_csn) begin
            if (!ram_wen) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_q <= ram[ram_addr];
            end
        end
    end

    // ---------------- behavioural model ----------------
    // rel_cnt = rising edges seen with reset released; the bridge is ready
    // once READY_AT of them have passed, and while scrubbing the scrub
    // address equals rel_cnt.
    logic [31:0] mdl [WORDS];
    bit          mdl_seeded = 1'b0;
    int          rel_cnt = 0;
    logic        exp_vld;
    logic [31:0] exp_dat;

    always @(posedge clk) begin
        logic g;
        int   a;
        if (!mdl_seeded) begin
            for (int i = 0; i < WORDS; i++) mdl[i] = seed(i);
            mdl_seeded = 1'b1;
        end
        g = rst_n && req && (rel_cnt >= READY_AT);
        a = int'(add[AW+1:2]);
        exp_vld = g;
        exp_dat = (g && wen) ? mdl[a] : 32'h0;
        if (g && !wen)
            for (int b = 0; b < 4; b++)
                if (be[b]) mdl[a][8*b +: 8] = wdata[8*b +: 8];
        if (SCRUB_M && rst_n && rel_cnt < READY_AT) mdl[rel_cnt] = 32'h0;
        if (!rst_n) rel_cnt = 0;
        else if (rel_cnt < 100000) rel_cnt++;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic ready_m, g, scrub_m;
        if (chk_en) begin
            ready_m = (rel_cnt >= READY_AT);
            g       = rst_n && req && ready_m;
            scrub_m = SCRUB_M && rst_n && !ready_m;
            chk("gnt", 32'(gnt), 32'(g));
            chk("init_done", 32'(init_done), 32'(ready_m));
            chk("r_valid", 32'(r_valid), 32'(exp_vld));
            chk("r_rdata", r_rdata, exp_dat);
            if (scrub_m) begin
                chk("scrub_csn", 32'(ram_csn), 32'd0);
                chk("scrub_wen", 32'(ram_wen), 32'd0);
                chk("scrub_be", 32'(ram_be), 32'hF);
                chk("scrub_wdata", ram_wdata, 32'h0);
                chk("scrub_addr", 32'(ram_addr), 32'(rel_cnt));
            end else if (g) begin
                chk("ram_csn", 32'(ram_csn), 32'd0);
                chk("ram_wen", 32'(ram_wen), 32'(wen));
                chk("ram_addr", 32'(ram_addr), 32'(add[AW+1:2]));
                if (!wen) begin
                    chk("ram_be", 32'(ram_be), 32'(be));
                    chk("ram_wdata", ram_wdata, wdata);
                end
            end else begin
                chk("ram_csn_idle", 32'(ram_csn), 32'd1);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic r, logic w, logic [31:0] a, logic [3:0] b, logic [31:0] d);
        req = r; wen = w; add = a; be = b; wdata = d;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!init_done && n < 200) begin
            cyc();
            @(negedge clk);
            n++;
        end
        if (!init_done) chk("ready_timeout", 32'(init_done), 32'd1);
    endtask

    initial begin
        int n;
        int nw;
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        cyc(); cyc();
        chk_en = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_csn", 32'(ram_csn), 32'd1);
        chk("rst_rvalid", 32'(r_valid), 32'd0);
        chk("rst_rdata", r_rdata, 32'h0);
        chk("rst_init", 32'(init_done), 32'd0);

        // held read request across release; counts wait cycles and scrub writes
        cyc();
        drive(1'b1, 1'b1, 32'h0, 4'hF, 32'h0);
        rst_n = 1'b1;
        n = 0; nw = 0;
        @(negedge clk);
        while (!init_done && n < 100) begin
            n++;
            chk("hold_gnt", 32'(gnt), 32'd0);
            if (!ram_csn) nw++;
            cyc();
            @(negedge clk);
        end
        n++;
        chk("ready_cycle", 32'(n), SCRUB_M ? 32'd17 : 32'd2);
        chk("scrub_writes", 32'(nw), SCRUB_M ? 32'd16 : 32'd0);
        chk("hold_gnt_ready", 32'(gnt), 32'd1);
        cyc();
        drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("hold_rvalid", 32'(r_valid), 32'd1);
        chk("hold_rdata", r_rdata, SCRUB_M ? 32'h0 : seed(0));

        // write then read same word, back to back
        cyc(); drive(1'b1, 1'b0, 32'h8, 4'hF, 32'hDEADBEEF);
        cyc(); drive(1'b1, 1'b1, 32'h8, 4'hF, 32'h0);
        @(negedge clk);
        chk("wr_rvalid", 32'(r_valid), 32'd1);
        chk("wr_rdata", r_rdata, 32'h0);
        cyc(); drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("rd_rvalid", 32'(r_valid), 32'd1);
        chk("rd_rdata", r_rdata, 32'hDEADBEEF);

        // partial write into a cleared word, read back through aliased address
        cyc(); drive(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        cyc(); drive(1'b1, 1'b0, 32'h10, 4'b0010, 32'h1234AB56);
        cyc(); drive(1'b1, 1'b1, 32'hFFFF_F013, 4'h0, 32'h0);
        cyc(); drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("partial_rdata", r_rdata, 32'h0000AB00);

        // reset while a response is pending cancels it
        cyc(); drive(1'b1, 1'b1, 32'h4, 4'hF, 32'h0);
        cyc(); drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("pend_rvalid", 32'(r_valid), 32'd1);
        cyc();
        @(negedge clk);
        chk("cancel_rvalid", 32'(r_valid), 32'd0);
        chk("cancel_init", 32'(init_done), 32'd0);
        cyc();
        rst_n = 1'b1;

`ifdef FPGA_RAM_SCRUB_EN
        // mid-scrub reset at address 7, scrub restarts from 0
        n = 0;
        @(negedge clk);
        while (ram_addr != AW'(7) && n < 40) begin
            cyc();
            @(negedge clk);
            n++;
        end
        chk("scrub_at7", 32'(ram_addr), 32'd7);
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_addr", 32'(ram_addr), 32'd0);
        chk("restart_csn", 32'(ram_csn), 32'd0);
`endif
        wait_ready();

        // randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            cyc();
            if ($urandom_range(0, 79) == 0) begin
                rst_n = 1'b0;
                drive(1'($urandom), 1'($urandom), $urandom, 4'($urandom), $urandom);
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) cyc();
                rst_n = 1'b1;
            end
            drive($urandom_range(0, 9) < 6, 1'($urandom), $urandom, 4'($urandom), $urandom);
        end
        cyc();
        drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule

// File: doc/fpga_ram_tcdm_bridge.md
FPGA_RAM_TCDM_BRIDGE -- requirements
Module: fpga_ram_tcdm_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, the RAM word-address width; it must match the downstream private RAM bank.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_ni, input, 1, synchronous active-low reset.
REQ-004 SHALL have port req_i, input, 1, TCDM request.
REQ-005 SHALL have port gnt_o, output, 1, TCDM grant.
REQ-006 SHALL have port add_i, input, 32, byte address.
REQ-007 SHALL have port wen_i, input, 1, 0 = write, 1 = read.
REQ-008 SHALL have port be_i, input, 4, byte enables.
REQ-009 SHALL have port wdata_i, input, 32, write data.
REQ-010 SHALL have port r_valid_o, output, 1, response valid.
REQ-011 SHALL have port r_rdata_o, output, 32, read data.
REQ-012 SHALL have port init_done_o, output, 1, high when the bridge accepts traffic.
REQ-013 SHALL have ports ram_csn_o (out, 1), ram_wen_o (out, 1), ram_be_o (out, 4), ram_addr_o (out, ADDR_WIDTH), ram_wdata_o (out, 32) and ram_rdata_i (in, 32), which drive the private RAM bank, whose read data is registered with 1-cycle latency.

Function
REQ-014 SHALL use two states, SCRUB and READY; it leaves SCRUB for READY only after the final scrub write and never returns to SCRUB except through reset.
REQ-015 In READY, gnt_o SHALL equal req_i combinationally, with zero wait states.
REQ-016 In SCRUB, gnt_o SHALL be 0 and req_i SHALL be ignored; requests stay pending and are not lost.
REQ-017 In READY, ram_csn_o SHALL be ~(req_i & gnt_o), ram_wen_o = wen_i, ram_be_o = be_i, ram_wdata_o = wdata_i, and ram_addr_o = add_i[ADDR_WIDTH+1:2]; higher address bits and bits [1:0] are ignored.
REQ-018 On every granted request, read or write, r_valid_o SHALL be 1 for exactly one cycle, on the cycle after the grant.
REQ-019 For a granted read, r_rdata_o SHALL equal ram_rdata_i in the r_valid_o cycle; for a granted write, r_rdata_o SHALL be 32'h0.
REQ-020 While r_valid_o is 0, r_rdata_o SHALL be 32'h0.
REQ-021 Back-to-back grants SHALL each produce one response, in order, with no bubble; a read following a write to the same address returns the new data.
REQ-022 In SCRUB, the bridge SHALL issue one write per cycle: ram_csn_o = 0, ram_wen_o = 0, ram_be_o = 4'hF, ram_wdata_o = 0, ram_addr_o = scrub counter.
REQ-023 The scrub counter SHALL be ADDR_WIDTH bits wide, start at 0 and increment by 1.
REQ-024 The write at address all-ones SHALL be the last scrub write; the counter must not wrap and rewrite address 0.
REQ-025 init_done_o SHALL rise on the cycle after the last scrub write, together with entry to READY.
REQ-026 Scrub writes SHALL never produce r_valid_o.

Reset
REQ-027 While rst_ni = 0 at a rising clk_i edge, the next state SHALL be SCRUB (or READY if the macro in REQ-031 is absent), with scrub counter = 0, r_valid_o = 0, r_rdata_o = 0 and init_done_o = 0.
REQ-028 During reset, ram_csn_o SHALL be 1 and gnt_o SHALL be 0; no RAM access is issued.
REQ-029 Reset asserted mid-scrub SHALL restart the scrub from address 0.
REQ-030 Reset asserted while a response is pending SHALL cancel it; r_valid_o = 0 on the following cycle.

Configuration
REQ-031 With macro FPGA_RAM_SCRUB_EN defined, the SCRUB state and scrub counter SHALL be present as specified above.
REQ-032 Without FPGA_RAM_SCRUB_EN, the bridge SHALL reset directly into READY, with init_done_o = 1 from the first cycle after reset release; no scrub counter logic is built.

Verification
REQ-033 Scrub, ADDR_WIDTH = 4: release reset -> exactly 16 writes to addresses 0..15 with be = F and data = 0; init_done_o rises on the 17th cycle after release.
REQ-034 Held request: req_i = 1 during scrub -> gnt_o = 0 until init_done_o = 1, then granted that same cycle, r_valid_o on the next cycle.
REQ-035 Write then read: write 0xDEADBEEF to add_i 0x8 with be = F, read 0x8 the next cycle -> two responses on consecutive cycles; the read returns 0xDEADBEEF and the write response carries 0.
REQ-036 Partial write: be = 4'b0010 with data 0x0000AB00 to a scrubbed word, then read -> 0x0000AB00.
REQ-037 Mid-scrub reset: assert rst_ni = 0 at scrub address 7 -> after release, the scrub restarts at address 0.
REQ-038 Macro absent: release reset, then read address 0 -> granted immediately, init_done_o = 1, and no scrub writes observed.
